// File: rtl/sw_pkg.sv
// Shared definitions for the sequence stream server: base codes, FSM encoding
// and default widths used by the server and its stores.
package sw_pkg;
  localparam int PE_SIZE_DEF = 64;
  localparam int SEQ_MAX_DEF = 1024;
  localparam int VEF_BIT_DEF = 16;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_e;
endpackage

// File: rtl/seq_ram.sv
// Simple 1W1R memory with a registered read port; a read of the address being
// written in the same cycle returns the new data.
module seq_ram #(
  parameter int DW    = 2,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/seq_stream_server.sv
// Holds the s and t sequences and streams their heads to the PE array, with t
// entries (plus v/f scores) written back every pass for the next pass.
module seq_stream_server import sw_pkg::*; #(
  parameter int PE_SIZE = PE_SIZE_DEF,
  parameter int SEQ_MAX = SEQ_MAX_DEF,
  parameter int VEF_BIT = VEF_BIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load_s_valid,
  input  logic               i_load_t_valid,
  input  logic [1:0]         i_load_base,
  input  logic               i_start,
  input  logic               i_finish,
  output logic               o_ready,
  output logic               o_data_valid,
  input  logic               i_update_s_w,
  input  logic               i_update_t_w,
  output logic [1:0]         o_s,
  output logic [1:0]         o_t,
  output logic               o_s_last,
  output logic               o_t_last,
  output logic [VEF_BIT-1:0] o_v,
  output logic [VEF_BIT-1:0] o_f,
  input  logic               i_t_valid,
  input  logic [1:0]         i_t,
  input  logic [VEF_BIT-1:0] i_v,
  input  logic [VEF_BIT-1:0] i_f,
  output logic [1:0]         o_dbg_state
);
  localparam int AW = $clog2(SEQ_MAX);
  localparam int LW = AW + 1;
  localparam int TW = 2 + 2 * VEF_BIT;
  localparam logic [LW-1:0] MAX_LEN = LW'(SEQ_MAX);
  localparam logic [LW-1:0] ONE_L   = LW'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  if (PE_SIZE < 1) begin : g_pe_size_check
    $error("seq_stream_server: PE_SIZE must be at least 1");
  end

  state_e        r_state;
  logic [LW-1:0] r_s_len, r_t_len, r_t_wr;
  logic [AW-1:0] r_s_rd, r_t_rd;
  logic [15:0]   r_pass;
  logic          r_valid, r_ready, r_s_last, r_t_last;

  logic          w_idle_load, w_serve, w_s_ld, w_t_ld, w_go, w_serve_nxt;
  logic          w_s_pop, w_t_pop, w_t_wrap, w_wb_we;
  logic [LW-1:0] w_s_len_nxt, w_t_len_nxt, w_t_wr_nxt;
  logic [AW-1:0] w_s_rd_nxt, w_t_rd_nxt, w_t_waddr, w_wb_addr;
  logic [15:0]   w_pass_nxt;
  logic          w_valid_nxt, w_s_last_nxt, w_t_last_nxt, w_t_we;
  logic [TW-1:0] w_t_wdata, w_t_rdata;
  logic [1:0]    w_s_rdata;

  // Handshake: a head is consumed on a cycle where o_data_valid and the matching
  // i_update_*_w are both high; the next head is presented on the following cycle.
  assign w_idle_load = (r_state == ST_IDLE) || (r_state == ST_LOAD);
  assign w_serve     = (r_state == ST_SERVE);
  assign w_s_ld      = w_idle_load && i_load_s_valid && (r_s_len < MAX_LEN);
  assign w_t_ld      = w_idle_load && i_load_t_valid && (r_t_len < MAX_LEN);
  assign w_go        = w_idle_load && i_start && (r_s_len != '0) && (r_t_len != '0);
  assign w_serve_nxt = w_go || (w_serve && !i_finish);
  assign w_s_pop     = w_serve && r_valid && i_update_s_w;
  assign w_t_pop     = w_serve && r_valid && i_update_t_w;
  assign w_t_wrap    = w_t_pop && ({1'b0, r_t_rd} == (r_t_len - ONE_L));
  assign w_wb_we     = w_serve && i_t_valid && (w_t_wrap || (r_t_wr < r_t_len));
  // A write-back that coincides with the wrap belongs to the next pass.
  assign w_wb_addr   = w_t_wrap ? '0 : r_t_wr[AW-1:0];

  always_comb begin
    w_s_len_nxt = r_s_len;
    w_t_len_nxt = r_t_len;
    w_s_rd_nxt  = r_s_rd;
    w_t_rd_nxt  = r_t_rd;
    w_t_wr_nxt  = r_t_wr;
    w_pass_nxt  = r_pass;
    if (w_s_ld) w_s_len_nxt = r_s_len + ONE_L;
    if (w_t_ld) w_t_len_nxt = r_t_len + ONE_L;
    if (w_go) begin
      w_s_rd_nxt = '0;
      w_t_rd_nxt = '0;
      w_t_wr_nxt = '0;
      w_pass_nxt = '0;
    end else begin
      if (w_s_pop && ({1'b0, r_s_rd} != (r_s_len - ONE_L))) w_s_rd_nxt = r_s_rd + ONE_A;
      if (w_t_wrap) begin
        w_t_rd_nxt = '0;
        w_t_wr_nxt = w_wb_we ? ONE_L : '0;
        if (r_pass != '1) w_pass_nxt = r_pass + 16'd1;
      end else begin
        if (w_t_pop) w_t_rd_nxt = r_t_rd + ONE_A;
        if (w_wb_we) w_t_wr_nxt = r_t_wr + ONE_L;
      end
    end
  end

  assign w_valid_nxt  = w_serve_nxt && ((w_pass_nxt == '0) || ({1'b0, w_t_rd_nxt} < w_t_wr_nxt));
  assign w_s_last_nxt = w_serve_nxt && ({1'b0, w_s_rd_nxt} == (w_s_len_nxt - ONE_L));
  assign w_t_last_nxt = w_serve_nxt && ({1'b0, w_t_rd_nxt} == (w_t_len_nxt - ONE_L));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_s_len  <= '0;
      r_t_len  <= '0;
      r_s_rd   <= '0;
      r_t_rd   <= '0;
      r_t_wr   <= '0;
      r_pass   <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
      r_s_last <= 1'b0;
      r_t_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) r_state <= ST_SERVE;
          else if (i_load_s_valid || i_load_t_valid) r_state <= ST_LOAD;
        end
        ST_LOAD:  if (w_go) r_state <= ST_SERVE;
        ST_SERVE: if (i_finish) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
      r_s_len  <= w_s_len_nxt;
      r_t_len  <= w_t_len_nxt;
      r_s_rd   <= w_s_rd_nxt;
      r_t_rd   <= w_t_rd_nxt;
      r_t_wr   <= w_t_wr_nxt;
      r_pass   <= w_pass_nxt;
      r_valid  <= w_valid_nxt;
      r_ready  <= !w_serve_nxt;
      r_s_last <= w_s_last_nxt;
      r_t_last <= w_t_last_nxt;
    end
  end

  assign w_t_we    = w_t_ld || w_wb_we;
  assign w_t_waddr = w_wb_we ? w_wb_addr : r_t_len[AW-1:0];
  assign w_t_wdata = w_wb_we ? {i_t, i_v, i_f} : {i_load_base, {(2 * VEF_BIT){1'b0}}};

  seq_ram #(.DW(2), .DEPTH(SEQ_MAX), .AW(AW)) u_s_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_s_ld),
    .i_waddr (r_s_len[AW-1:0]),
    .i_wdata (i_load_base),
    .i_re    (w_serve_nxt),
    .i_raddr (w_s_rd_nxt),
    .o_rdata (w_s_rdata)
  );

  seq_ram #(.DW(TW), .DEPTH(SEQ_MAX), .AW(AW)) u_t_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_t_we),
    .i_waddr (w_t_waddr),
    .i_wdata (w_t_wdata),
    .i_re    (w_serve_nxt),
    .i_raddr (w_t_rd_nxt),
    .o_rdata (w_t_rdata)
  );

  // Pass 0 reports zero scores; later passes only expose entries written back
  // this pass, so stale v/f in the store is never visible.
  assign o_s          = w_s_rdata;
  assign o_t          = w_t_rdata[TW-1 -: 2];
  assign o_v          = (r_pass == '0) ? '0 : w_t_rdata[2*VEF_BIT-1 -: VEF_BIT];
  assign o_f          = (r_pass == '0) ? '0 : w_t_rdata[VEF_BIT-1:0];
  assign o_s_last     = r_s_last;
  assign o_t_last     = r_t_last;
  assign o_data_valid = r_valid;
  assign o_ready      = r_ready;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_seq_stream_server.sv
// Directed bench for seq_stream_server: a queue/array model of the stores is
// compared every cycle, plus literal expectations at key points.
module tb_seq_stream_server;
  localparam int SEQ_MAX = 8;
  localparam int VB      = 16;

  logic          clk, rst_n;
  logic          i_load_s_valid, i_load_t_valid, i_start, i_finish;
  logic [1:0]    i_load_base, i_t;
  logic          i_update_s_w, i_update_t_w, i_t_valid;
  logic [VB-1:0] i_v, i_f;
  logic          o_ready, o_data_valid, o_s_last, o_t_last;
  logic [1:0]    o_s, o_t, o_dbg_state;
  logic [VB-1:0] o_v, o_f;

  seq_stream_server #(.PE_SIZE(64), .SEQ_MAX(SEQ_MAX), .VEF_BIT(VB)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_load_s_valid(i_load_s_valid), .i_load_t_valid(i_load_t_valid),
    .i_load_base(i_load_base), .i_start(i_start), .i_finish(i_finish),
    .o_ready(o_ready), .o_data_valid(o_data_valid),
    .i_update_s_w(i_update_s_w), .i_update_t_w(i_update_t_w),
    .o_s(o_s), .o_t(o_t), .o_s_last(o_s_last), .o_t_last(o_t_last),
    .o_v(o_v), .o_f(o_f),
    .i_t_valid(i_t_valid), .i_t(i_t), .i_v(i_v), .i_f(i_f),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: 0 idle, 1 load, 2 serve
  int            m_state = 0;
  int            m_s_len = 0, m_t_len = 0, m_s_rd = 0, m_t_rd = 0, m_t_wr = 0, m_pass = 0;
  logic [1:0]    m_s [SEQ_MAX];
  logic [1:0]    m_t [SEQ_MAX];
  logic [VB-1:0] m_v [SEQ_MAX];
  logic [VB-1:0] m_f [SEQ_MAX];

  function automatic bit m_valid();
    return (m_state == 2) && ((m_pass == 0) || (m_t_rd < m_t_wr));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit vld, start_ok, wrap;
    if (!rst_n) begin
      m_state = 0; m_s_len = 0; m_t_len = 0;
      m_s_rd = 0; m_t_rd = 0; m_t_wr = 0; m_pass = 0;
    end else if (m_state != 2) begin
      start_ok = i_start && (m_s_len > 0) && (m_t_len > 0);
      if (i_load_s_valid && m_s_len < SEQ_MAX) begin
        m_s[m_s_len] = i_load_base; m_s_len++;
      end
      if (i_load_t_valid && m_t_len < SEQ_MAX) begin
        m_t[m_t_len] = i_load_base; m_v[m_t_len] = '0; m_f[m_t_len] = '0; m_t_len++;
      end
      if (start_ok) begin
        m_state = 2; m_s_rd = 0; m_t_rd = 0; m_t_wr = 0; m_pass = 0;
      end else if (i_load_s_valid || i_load_t_valid) begin
        m_state = 1;
      end
    end else begin
      vld  = m_valid();
      wrap = vld && i_update_t_w && (m_t_rd == m_t_len - 1);
      if (vld && i_update_s_w && m_s_rd < m_s_len - 1) m_s_rd++;
      if (i_t_valid) begin
        if (wrap) begin
          m_t[0] = i_t; m_v[0] = i_v; m_f[0] = i_f; m_t_wr = 1;
        end else if (m_t_wr < m_t_len) begin
          m_t[m_t_wr] = i_t; m_v[m_t_wr] = i_v; m_f[m_t_wr] = i_f; m_t_wr++;
        end
      end
      if (wrap) begin
        m_t_rd = 0; m_pass++;
        if (!i_t_valid) m_t_wr = 0;
      end else if (vld && i_update_t_w) begin
        m_t_rd++;
      end
      if (i_finish) m_state = 0;
    end
  end

  // compare process (scoreboard against the model)
  always @(negedge clk) begin
    chk("ready", 32'(o_ready), 32'(m_state != 2));
    chk("data_valid", 32'(o_data_valid), 32'(m_valid()));
    chk("state", 32'(o_dbg_state), 32'(m_state));
    if (m_valid()) begin
      chk("s_head", 32'(o_s), 32'(m_s[m_s_rd]));
      chk("t_head", 32'(o_t), 32'(m_t[m_t_rd]));
      chk("v_head", 32'(o_v), (m_pass == 0) ? 32'd0 : 32'(m_v[m_t_rd]));
      chk("f_head", 32'(o_f), (m_pass == 0) ? 32'd0 : 32'(m_f[m_t_rd]));
      chk("s_last", 32'(o_s_last), 32'(m_s_rd == m_s_len - 1));
      chk("t_last", 32'(o_t_last), 32'(m_t_rd == m_t_len - 1));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_load_s_valid = 0; i_load_t_valid = 0; i_load_base = 0;
    i_start = 0; i_finish = 0; i_update_s_w = 0; i_update_t_w = 0;
    i_t_valid = 0; i_t = 0; i_v = 0; i_f = 0;
  endtask

  task automatic load(input bit is_t, input logic [1:0] b);
    i_load_s_valid = !is_t; i_load_t_valid = is_t; i_load_base = b;
    cyc();
    clear_in();
  endtask

  task automatic pulse_start();
    i_start = 1; cyc(); clear_in();
  endtask

  task automatic pulse_finish();
    i_finish = 1; cyc(); clear_in();
  endtask

  task automatic step(input bit ps, input bit pt, input bit wb,
                      input logic [1:0] t, input logic [VB-1:0] v, input logic [VB-1:0] f);
    i_update_s_w = ps; i_update_t_w = pt; i_t_valid = wb; i_t = t; i_v = v; i_f = f;
    cyc();
    clear_in();
  endtask

  task automatic head(input string tag, input bit vld, input logic [1:0] s, input logic [1:0] t,
                      input logic [VB-1:0] v, input logic [VB-1:0] f);
    chk({tag, ".valid"}, 32'(o_data_valid), 32'(vld));
    if (vld) begin
      chk({tag, ".s"}, 32'(o_s), 32'(s));
      chk({tag, ".t"}, 32'(o_t), 32'(t));
      chk({tag, ".v"}, 32'(o_v), 32'(v));
      chk({tag, ".f"}, 32'(o_f), 32'(f));
    end
  endtask

  initial begin
    logic [1:0] s_exp [5];
    s_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    clear_in();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.valid", 32'(o_data_valid), 32'd0);
    chk("rst.s", 32'(o_s), 32'd0);
    chk("rst.v", 32'(o_v), 32'd0);
    chk("rst.s_last", 32'(o_s_last), 32'd0);

    pulse_start();
    chk("empty_start.state", 32'(o_dbg_state), 32'd0);
    chk("empty_start.ready", 32'(o_ready), 32'd1);

    // s = ACGT; start with t still empty must be ignored
    load(0, 2'd0); load(0, 2'd1); load(0, 2'd2); load(0, 2'd3);
    chk("load.state", 32'(o_dbg_state), 32'd1);
    pulse_start();
    chk("no_t_start.state", 32'(o_dbg_state), 32'd1);
    chk("no_t_start.ready", 32'(o_ready), 32'd1);
    load(1, 2'd0); load(1, 2'd1); load(1, 2'd2);
    pulse_start();
    chk("serve.ready", 32'(o_ready), 32'd0);
    chk("serve.state", 32'(o_dbg_state), 32'd2);
    head("first", 1, 2'd0, 2'd0, 0, 0);

    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0, 0, 0);
      chk("s_pop.s", 32'(o_s), 32'(s_exp[i]));
      chk("s_pop.s_last", 32'(o_s_last), 32'(i >= 3));
    end

    // pass 0 over t = ACG
    step(0, 1, 0, 0, 0, 0);
    head("p0_t1", 1, 2'd3, 2'd1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    head("p0_t2", 1, 2'd3, 2'd2, 0, 0);
    chk("p0.t_last", 32'(o_t_last), 32'd1);
    step(0, 1, 0, 0, 0, 0);
    chk("p0_wrap.valid", 32'(o_data_valid), 32'd0);

    // pass 1 write-back, then pop-wrap with a simultaneous write-back
    step(0, 0, 1, 2'd2, 16'd5, 16'd3);
    head("wb0", 1, 2'd3, 2'd2, 16'd5, 16'd3);
    step(0, 0, 1, 2'd1, 16'd7, 16'd8);
    step(0, 0, 1, 2'd3, 16'd9, 16'd4);
    step(0, 1, 0, 0, 0, 0);
    head("p1_t1", 1, 2'd3, 2'd1, 16'd7, 16'd8);
    step(0, 1, 0, 0, 0, 0);
    head("p1_t2", 1, 2'd3, 2'd3, 16'd9, 16'd4);
    step(0, 1, 1, 2'd0, 16'd11, 16'd12);
    head("wrap_wb", 1, 2'd3, 2'd0, 16'd11, 16'd12);
    step(0, 1, 0, 0, 0, 0);
    chk("wrap_wb.t_wr_is_1", 32'(o_data_valid), 32'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("gated_pop.valid", 32'(o_data_valid), 32'd0);
    step(0, 0, 1, 2'd1, 16'd1, 16'd1);
    head("p2_t1", 1, 2'd3, 2'd1, 16'd1, 16'd1);
    step(0, 0, 1, 2'd2, 16'd2, 16'd2);
    step(1, 1, 0, 0, 0, 0);
    head("both_pop", 1, 2'd3, 2'd2, 16'd2, 16'd2);

    pulse_finish();
    chk("finish.ready", 32'(o_ready), 32'd1);
    chk("finish.valid", 32'(o_data_valid), 32'd0);

    // restart: stored v/f are hidden again in pass 0
    pulse_start();
    head("restart", 1, 2'd0, 2'd0, 16'd0, 16'd0);
    step(1, 1, 0, 0, 0, 0);
    head("restart_pop", 1, 2'd1, 2'd1, 16'd0, 16'd0);

    // asynchronous reset mid-serve
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(o_data_valid), 32'd0);
    chk("midrst.ready", 32'(o_ready), 32'd1);
    chk("midrst.state", 32'(o_dbg_state), 32'd0);
    cyc();
    rst_n = 1'b1;
    i_update_s_w = 1; i_update_t_w = 1; i_t_valid = 1; i_start = 1;
    cyc();
    clear_in();
    chk("post_rst.state", 32'(o_dbg_state), 32'd0);
    chk("post_rst.valid", 32'(o_data_valid), 32'd0);

    // store saturation at SEQ_MAX
    for (int i = 0; i < 10; i++) load(0, 2'(i % 4));
    load(1, 2'd2);
    pulse_start();
    head("sat", 1, 2'd0, 2'd2, 0, 0);
    chk("sat.t_last", 32'(o_t_last), 32'd1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, 0);
    chk("sat.s", 32'(o_s), 32'd3);
    chk("sat.s_last", 32'(o_s_last), 32'd1);
    pulse_finish();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected end by %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/seq_stream_server.md
SEQ_STREAM_SERVER -- requirements
Module: seq_stream_server

Interface
REQ-001 SHALL have parameter PE_SIZE, default 64, number of PEs (s chunk length).
REQ-002 SHALL have parameter SEQ_MAX, default 1024, capacity of s and t stores; AW = clog2(SEQ_MAX).
REQ-003 SHALL have parameter VEF_BIT, default 16, width of v/f scores.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_load_s_valid, i_load_t_valid  in  1 each  append i_load_base to the s or t store.
REQ-007 SHALL have port i_load_base  in  2  base code.
REQ-008 SHALL have ports i_start, i_finish  in  1  begin serving; return to idle.
REQ-009 SHALL have port o_ready  out  1  high in IDLE/LOAD.
REQ-010 SHALL have port o_data_valid  out  1  current s and t heads are valid.
REQ-011 SHALL have ports i_update_s_w, i_update_t_w  in  1 each  pop s head; pop t head.
REQ-012 SHALL have ports o_s, o_t  out  2 each  s head; t head.
REQ-013 SHALL have ports o_s_last, o_t_last  out  1 each  head is final s; head is final t.
REQ-014 SHALL have ports o_v, o_f  out  VEF_BIT each  v/f paired with t head.
REQ-015 SHALL have ports i_t_valid, i_t, i_v, i_f  in  1/2/VEF_BIT/VEF_BIT  write-back of one t entry.

Function
REQ-016 SHALL implement states IDLE, LOAD, SERVE; IDLE->LOAD on any load strobe; IDLE/LOAD->SERVE on i_start when s_len>0 and t_len>0; SERVE->IDLE on i_finish; i_start with an empty store SHALL be ignored.
REQ-017 In LOAD, each load strobe SHALL write at s_len/t_len and increment it; writes at SEQ_MAX SHALL be dropped (saturate); loads outside IDLE/LOAD SHALL be ignored.
REQ-018 Entering SERVE SHALL clear s_rd, t_rd, t_wr, pass to 0 and zero all v/f entries.
REQ-019 o_s, o_t, o_v, o_f, o_s_last, o_t_last SHALL be registered show-ahead heads, valid the cycle o_data_valid is high.
REQ-020 o_data_valid SHALL be high in SERVE iff pass==0 or t_rd < t_wr (t entry already written back this pass).
REQ-021 A pop SHALL occur only when update and o_data_valid are both high; new head SHALL appear next cycle.
REQ-022 s pop SHALL increment s_rd; at s_rd==s_len-1 o_s_last SHALL stay high and further pops SHALL not advance.
REQ-023 t pop at t_rd==t_len-1 SHALL wrap t_rd to 0, increment pass, and clear t_wr to 0; otherwise increment t_rd.
REQ-024 Write-back SHALL store i_t, i_v, i_f at t_wr and increment t_wr, saturating at t_len; simultaneous pop-wrap and write-back SHALL leave t_wr = 1 (write lands at index 0... of next pass).
REQ-025 In pass 0 o_v and o_f SHALL be 0; in pass>0 they SHALL be the written-back values.
REQ-026 Simultaneous s and t pops SHALL both take effect in one cycle.

Reset
REQ-027 Reset SHALL force IDLE, s_len=t_len=s_rd=t_rd=t_wr=pass=0, all outputs 0 except o_ready=1; stores need not be cleared.
REQ-028 Reset mid-SERVE SHALL abort immediately; no further pops or write-backs SHALL be accepted until reload.

Structure
REQ-029 Base codes, state encodings, VEF_BIT, PE_SIZE default SHALL live in the shared sw_pkg package.
REQ-030 One sub-module seq_ram (1W1R, registered read) SHALL be used for the s store and the t/v/f store.

Verification
REQ-031 Load s=ACGT, t=ACG, start, pop s four times -> o_s 0,1,2,3, o_s_last high on 4th head, 5th pop holds 3.
REQ-032 Pass 0: pop t three times -> o_v=o_f=0, o_t_last on 3rd, t_rd wraps to 0, o_data_valid drops.
REQ-033 Write-back (t=2,v=5,f=3) -> next cycle o_data_valid=1, head o_t=2, o_v=5, o_f=3.
REQ-034 Pop-wrap and write-back same cycle -> t_wr=1, index 0 holds written value.
REQ-035 i_start with t_len=0 -> stays IDLE, o_ready=1.
REQ-036 rst_n low mid-SERVE -> next edge o_data_valid=0, o_ready=1, lengths 0.
